fetch_sequencer: RTL and testbench

Multi-cycle instruction-fetch controller that owns the program counter and sequences it against a handshaked instruction memory. It issues one fetch at a time, hands each instruction to decode with a valid/ready handshake, and applies branch/jump redirects from execute. Redirects flush any in-flight or held instruction. It sits between the instruction memory and the decode stage, and replaces the free-running single-cycle PC update.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/next_pc_sel.sv | 28 ++
 rtl/fetch_sequencer.sv | 146 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int unsigned ADDR_W_DEF     = 32;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned COUNT_W        = 32;
    localparam int unsigned INST_BYTES     = 4;
    localparam logic [31:0] RESET_ADDR_DEF = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_HALT = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational redirect decode, target select/alignment and sequential PC increment.
module next_pc_sel
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              branch_i,
    input  logic              zero_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_target_i,
    output logic              redirect_c,
    output logic [ADDR_W-1:0] target_c,
    output logic [ADDR_W-1:0] pc_inc_c
);

    logic [ADDR_W-1:0] sel_target;

    // Jump has priority over a taken branch; targets are word aligned.
    always_comb begin
        redirect_c = jump_i | (branch_i & zero_i);
        sel_target = jump_i ? jump_target_i : branch_target_i;
        target_c   = sel_target & ~ADDR_W'(INST_BYTES - 1);
        pc_inc_c   = pc_i + ADDR_W'(INST_BYTES);
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch controller: owns the PC, issues one imem request at a time,
// holds the returned instruction for decode and applies execute redirects.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W     = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0]  RESET_ADDR = ADDR_W'(RESET_ADDR_DEF)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic                halt,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ready,
    input  logic                imem_rvalid,
    input  logic [DATA_W-1:0]   imem_rdata,
    output logic                inst_valid,
    output logic [DATA_W-1:0]   inst,
    output logic [ADDR_W-1:0]   inst_pc,
    input  logic                inst_ready,
    input  logic                branch,
    input  logic                zero,
    input  logic [ADDR_W-1:0]   branch_target,
    input  logic                jump,
    input  logic [ADDR_W-1:0]   jump_target,
    output logic [ADDR_W-1:0]   pc,
    output logic [COUNT_W-1:0]  fetch_count
);

    fetch_state_e        state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   inst_pc_q;
    logic [DATA_W-1:0]   inst_q;
    logic [COUNT_W-1:0]  fetch_count_q;
    logic                drop_q;
    logic                req_q;
    logic                inst_valid_q;

    logic                redirect_c;
    logic [ADDR_W-1:0]   target_c;
    logic [ADDR_W-1:0]   pc_inc_c;

    next_pc_sel #(.ADDR_W(ADDR_W)) u_next_pc_sel (
        .pc_i            (pc_q),
        .branch_i        (branch),
        .zero_i          (zero),
        .branch_target_i (branch_target),
        .jump_i          (jump),
        .jump_target_i   (jump_target),
        .redirect_c      (redirect_c),
        .target_c        (target_c),
        .pc_inc_c        (pc_inc_c)
    );

    // drop_q marks an accepted request whose data must be discarded on return.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_ADDR;
            inst_pc_q     <= '0;
            inst_q        <= '0;
            fetch_count_q <= '0;
            drop_q        <= 1'b0;
            req_q         <= 1'b0;
            inst_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_REQ;
                        req_q   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (halt && !imem_ready) begin
                        state_q <= ST_HALT;
                        req_q   <= 1'b0;
                    end else begin
                        if (redirect_c) begin
                            pc_q <= target_c;
                        end
                        if (imem_ready) begin
                            drop_q  <= redirect_c;
                            state_q <= ST_WAIT;
                            req_q   <= 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (redirect_c) begin
                        pc_q   <= target_c;
                        drop_q <= 1'b1;
                    end
                    if (imem_rvalid) begin
                        if (drop_q || redirect_c) begin
                            drop_q  <= 1'b0;
                            state_q <= ST_REQ;
                            req_q   <= 1'b1;
                        end else begin
                            inst_q        <= imem_rdata;
                            inst_pc_q     <= pc_q;
                            inst_valid_q  <= 1'b1;
                            pc_q          <= pc_inc_c;
                            fetch_count_q <= fetch_count_q + COUNT_W'(1);
                            state_q       <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    // A redirect flushes the held (younger) instruction even if decode takes it.
                    if (redirect_c) begin
                        inst_valid_q <= 1'b0;
                        pc_q         <= target_c;
                        state_q      <= ST_REQ;
                        req_q        <= 1'b1;
                    end else if (inst_ready) begin
                        inst_valid_q <= 1'b0;
                        if (halt) begin
                            state_q <= ST_HALT;
                        end else begin
                            state_q <= ST_REQ;
                            req_q   <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign inst_valid  = inst_valid_q;
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign pc          = pc_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a randomized run against a stream-level model.
module tb_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start, halt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst, inst_pc;
    logic        inst_ready;
    logic        branch, zero, jump;
    logic [31:0] branch_target, jump_target;
    logic [31:0] pc, fetch_count;

    int compared   = 0;
    int mismatched = 0;

    int unsigned pend_cnt;
    logic [31:0] pend_addr;
    bit          rand_mode, data_fixed, mem_ready_en;
    int unsigned mem_lat;

    fetch_sequencer dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .halt          (halt),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready),
        .branch        (branch),
        .zero          (zero),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .pc            (pc),
        .fetch_count   (fetch_count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a * 32'h0001_0003 + 32'h13;
    endfunction

    function automatic logic [31:0] pick_target();
        if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        return $urandom & 32'h0000_FFFF;
    endfunction

    // Instruction memory model: one response per accepted request after a latency.
    task automatic mem_drive();
        imem_rvalid = 1'b0;
        if (pend_cnt != 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = data_fixed ? 32'h0000_0013 : memf(pend_addr);
            end
        end
        imem_ready = 1'b0;
        if (imem_req === 1'b1 && (rand_mode ? ($urandom_range(0, 1) == 1) : mem_ready_en)) begin
            imem_ready = 1'b1;
            pend_cnt   = rand_mode ? $urandom_range(1, 3) : mem_lat;
            pend_addr  = imem_addr;
        end
    endtask

    task automatic cycle();
        @(negedge clock);
        mem_drive();
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (imem_req === 1'b1) ok = 1'b1;
            else cycle();
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (inst_valid === 1'b1) ok = 1'b1;
            else cycle();
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; start = 1'b0; halt = 1'b0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
        branch = 1'b0; zero = 1'b0; branch_target = '0; jump = 1'b0; jump_target = '0;
        pend_cnt = 0; rand_mode = 1'b0; data_fixed = 1'b0; mem_ready_en = 1'b1; mem_lat = 1;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        start = 1'b1;
        repeat (6) cycle();
        reset_n = 1'b0;
        #1;
        compared++; if (pc !== 32'h0) begin mismatched++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL reset_req: got %b want 0", imem_req); end
        compared++; if (inst_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        compared++; if (inst !== 32'h0) begin mismatched++; $display("FAIL reset_inst: got %h want 0", inst); end
        compared++; if (inst_pc !== 32'h0) begin mismatched++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc); end
        compared++; if (fetch_count !== 32'h0) begin mismatched++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
    endtask

    task automatic test_sequential();
        bit ok;
        do_reset();
        data_fixed = 1'b1; start = 1'b1; inst_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            wait_req(ok);
            compared++; if (!ok || imem_addr !== 32'(4 * n)) begin mismatched++; $display("FAIL seq_addr%0d: got %h (req seen %b) want %h", n, imem_addr, ok, 32'(4 * n)); end
            wait_valid(ok);
            compared++; if (!ok || inst_pc !== 32'(4 * n) || inst !== 32'h13) begin mismatched++; $display("FAIL seq_inst%0d: got pc %h inst %h (valid seen %b) want pc %h inst 00000013", n, inst_pc, inst, ok, 32'(4 * n)); end
        end
        compared++; if (fetch_count !== 32'd3) begin mismatched++; $display("FAIL seq_count: got %0d want 3", fetch_count); end
    endtask

    task automatic test_backpressure();
        bit ok, bad;
        do_reset();
        start = 1'b1; inst_ready = 1'b1;
        wait_valid(ok);
        cycle();
        inst_ready = 1'b0;
        wait_valid(ok);
        compared++; if (!ok || inst_pc !== 32'h4) begin mismatched++; $display("FAIL bp_hold_pc: got %h (valid seen %b) want 00000004", inst_pc, ok); end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (inst_valid !== 1'b1 || inst !== memf(32'h4) || inst_pc !== 32'h4 || imem_req !== 1'b0) bad = 1'b1;
        end
        compared++; if (bad) begin mismatched++; $display("FAIL bp_stable: got valid %b inst %h req %b want 1 %h 0", inst_valid, inst, imem_req, memf(32'h4)); end
        inst_ready = 1'b1;
        cycle();
        compared++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin mismatched++; $display("FAIL bp_next_addr: got req %b addr %h want 1 00000008", imem_req, imem_addr); end
    endtask

    task automatic test_branch_in_wait();
        bit ok, seen_valid, got_req;
        do_reset();
        start = 1'b1; inst_ready = 1'b1;
        for (int n = 0; n < 2; n++) begin
            wait_req(ok);
            wait_valid(ok);
        end
        mem_lat = 3;
        wait_req(ok);
        compared++; if (!ok || imem_addr !== 32'h8) begin mismatched++; $display("FAIL bw_req8: got %h want 00000008", imem_addr); end
        cycle();
        branch = 1'b1; zero = 1'b1; branch_target = 32'h40;
        cycle();
        branch = 1'b0; zero = 1'b0;
        compared++; if (pc !== 32'h40) begin mismatched++; $display("FAIL bw_pc: got %h want 00000040", pc); end
        seen_valid = 1'b0; got_req = 1'b0;
        for (int i = 0; i < 20 && !got_req; i++) begin
            cycle();
            if (inst_valid !== 1'b0) seen_valid = 1'b1;
            if (imem_req === 1'b1) got_req = 1'b1;
        end
        compared++; if (seen_valid || !got_req) begin mismatched++; $display("FAIL bw_discard: got valid_seen %b req_seen %b want 0 1", seen_valid, got_req); end
        compared++; if (imem_addr !== 32'h40) begin mismatched++; $display("FAIL bw_addr: got %h want 00000040", imem_addr); end
        compared++; if (fetch_count !== 32'd2) begin mismatched++; $display("FAIL bw_count: got %0d want 2", fetch_count); end
    endtask

    task automatic test_jump_branch_hold();
        bit ok;
        do_reset();
        start = 1'b1; inst_ready = 1'b0;
        wait_valid(ok);
        compared++; if (!ok || inst_pc !== 32'h0) begin mismatched++; $display("FAIL jb_first: got %h want 00000000", inst_pc); end
        jump = 1'b1; jump_target = 32'h103; branch = 1'b1; zero = 1'b1; branch_target = 32'h80; inst_ready = 1'b1;
        cycle();
        jump = 1'b0; branch = 1'b0; zero = 1'b0;
        compared++; if (inst_valid !== 1'b0) begin mismatched++; $display("FAIL jb_flush: got %b want 0", inst_valid); end
        compared++; if (pc !== 32'h100) begin mismatched++; $display("FAIL jb_pc: got %h want 00000100", pc); end
        compared++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin mismatched++; $display("FAIL jb_addr: got req %b addr %h want 1 00000100", imem_req, imem_addr); end
        compared++; if (fetch_count !== 32'd1) begin mismatched++; $display("FAIL jb_count: got %0d want 1", fetch_count); end
        wait_valid(ok);
        compared++; if (!ok || inst_pc !== 32'h100) begin mismatched++; $display("FAIL jb_target_inst: got %h want 00000100", inst_pc); end
        branch = 1'b1; zero = 1'b0; branch_target = 32'h80;
        cycle();
        branch = 1'b0;
        compared++; if (imem_req !== 1'b1 || imem_addr !== 32'h104 || pc !== 32'h104) begin mismatched++; $display("FAIL nt_seq: got req %b addr %h pc %h want 1 00000104 00000104", imem_req, imem_addr, pc); end
    endtask

    task automatic test_reset_mid_wait();
        bit ok, bad;
        do_reset();
        start = 1'b1; inst_ready = 1'b1; mem_lat = 3;
        wait_req(ok);
        cycle();
        start = 1'b0;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        #1;
        compared++; if (pc !== 32'h0 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin mismatched++; $display("FAIL rw_reset: got pc %h req %b valid %b want 0 0 0", pc, imem_req, inst_valid); end
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (inst_valid !== 1'b0 || imem_req !== 1'b0 || fetch_count !== 32'h0 || pc !== 32'h0) bad = 1'b1;
        end
        compared++; if (bad) begin mismatched++; $display("FAIL rw_stray: got valid %b req %b count %0d pc %h want 0 0 0 0", inst_valid, imem_req, fetch_count, pc); end
    endtask

    task automatic test_halt();
        bit ok, bad;
        do_reset();
        mem_ready_en = 1'b0; start = 1'b1; halt = 1'b1;
        wait_req(ok);
        compared++; if (!ok) begin mismatched++; $display("FAIL halt_req: got no request want one"); end
        cycle();
        halt = 1'b0; mem_ready_en = 1'b1; inst_ready = 1'b1; jump = 1'b1; jump_target = 32'h200;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (imem_req !== 1'b0 || inst_valid !== 1'b0 || pc !== 32'h0) bad = 1'b1;
        end
        jump = 1'b0;
        compared++; if (bad) begin mismatched++; $display("FAIL halt_stuck: got req %b valid %b pc %h want 0 0 0", imem_req, inst_valid, pc); end
    endtask

    // Stream-level model: the next delivered instruction is the last redirect target,
    // advanced by 4 for every instruction decode accepts.
    task automatic test_random();
        logic [31:0] exp_pc;
        int          delivered, since;
        bit          prev_valid, stop;
        do_reset();
        rand_mode = 1'b1; start = 1'b1;
        exp_pc = 32'h0; delivered = 0; since = 0; prev_valid = 1'b0; stop = 1'b0;
        for (int c = 0; c < 3000 && !stop; c++) begin
            @(negedge clock);
            if (imem_req === 1'b1) begin
                compared++; if (imem_addr !== exp_pc) begin mismatched++; $display("FAIL rnd_addr c%0d: got %h want %h", c, imem_addr, exp_pc); end
                compared++; if (pend_cnt != 0) begin mismatched++; $display("FAIL rnd_outstanding c%0d: got request with %0d pending want none", c, pend_cnt); end
            end
            if (inst_valid === 1'b1) begin
                compared++; if (inst_pc !== exp_pc || inst !== memf(exp_pc)) begin mismatched++; $display("FAIL rnd_inst c%0d: got pc %h inst %h want %h %h", c, inst_pc, inst, exp_pc, memf(exp_pc)); end
                if (!prev_valid) begin
                    delivered++; since = 0;
                    compared++; if (fetch_count !== 32'(delivered)) begin mismatched++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, fetch_count, delivered); end
                end
            end
            prev_valid = (inst_valid === 1'b1);
            since++;
            if (since > 200) begin
                compared++; mismatched++;
                $display("FAIL rnd_timeout c%0d: got no delivery for 200 cycles want progress", c);
                stop = 1'b1;
            end
            mem_drive();
            inst_ready = ($urandom_range(0, 2) != 0);
            jump = 1'b0; branch = 1'b0; zero = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 15))
                0: jump = 1'b1;
                1: branch = 1'b1;
                2: begin jump = 1'b1; branch = 1'b1; end
                default: ;
            endcase
            jump_target = pick_target(); branch_target = pick_target();
            if (jump || (branch && zero)) exp_pc = (jump ? jump_target : branch_target) & ~32'h3;
            else if (inst_valid === 1'b1 && inst_ready) exp_pc = exp_pc + 32'd4;
        end
        compared++; if (delivered < 30) begin mismatched++; $display("FAIL rnd_progress: got %0d deliveries want at least 30", delivered); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_branch_in_wait();
        test_jump_branch_hold();
        test_reset_mid_wait();
        test_halt();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish within 1 ms want finish");
        $fatal(1, "timeout");
    end

endmodule
